// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code constants, op type and legal-op check.
// Used by the ALU controller and the execute stage alike.
`timescale 1ns/1ps
package alu_pkg;

    typedef logic [3:0] op_t;

    localparam op_t ALU_AND = 4'b0000;
    localparam op_t ALU_OR  = 4'b0001;
    localparam op_t ALU_ADD = 4'b0010;
    localparam op_t ALU_SUB = 4'b0110;
    localparam op_t ALU_SLT = 4'b0111;
    localparam op_t ALU_NOR = 4'b1100;

    // True for the six defined operation codes.
    function automatic logic is_legal_op(input op_t op);
        logic legal;
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: legal = 1'b1;
            default:                                            legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: op, a, b -> result, zero flag, illegal-op flag.
// Illegal codes yield a zero result (so zero = 1) with the illegal flag set.
`timescale 1ns/1ps
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [3:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_result,
    output logic              o_zero,
    output logic              o_illegal
);

    logic [DATA_W-1:0] w_result;
    logic              w_lt;

    assign w_lt = $signed(i_a) < $signed(i_b);

    // Result select; carries and overflow are simply dropped.
    always_comb begin
        w_result = '0;
        case (i_op)
            ALU_AND: w_result = i_a & i_b;
            ALU_OR:  w_result = i_a | i_b;
            ALU_ADD: w_result = i_a + i_b;
            ALU_SUB: w_result = i_a - i_b;
            ALU_SLT: w_result = {{(DATA_W-1){1'b0}}, w_lt};
            ALU_NOR: w_result = ~(i_a | i_b);
            default: w_result = '0;
        endcase
    end

    assign o_result  = w_result;
    assign o_zero    = (w_result == '0);
    assign o_illegal = !is_legal_op(i_op);

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage with valid/ready on both sides.
// Build option: define ALU_EXEC_SKID_EN to add a 1-entry skid register behind the
// output register, making in_ready a pure register output (capacity 2). Without it
// the stage holds one entry and in_ready = !out_valid || out_ready.
`timescale 1ns/1ps
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [TAG_W-1:0]  in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic [TAG_W-1:0]  out_rd,
    output logic              out_illegal
);

    // ALU ahead of the registers
    logic [DATA_W-1:0] w_core_result;
    logic              w_core_zero;
    logic              w_core_illegal;

    alu_core #(
        .DATA_W (DATA_W)
    ) u_alu_core (
        .i_op      (in_op),
        .i_a       (in_a),
        .i_b       (in_b),
        .o_result  (w_core_result),
        .o_zero    (w_core_zero),
        .o_illegal (w_core_illegal)
    );

    // Output register
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_result;
    logic              r_out_zero;
    logic [TAG_W-1:0]  r_out_rd;
    logic              r_out_illegal;

    // Next entry for the output register and its load strobe
    logic              w_accept;
    logic              w_out_load;
    logic [DATA_W-1:0] w_next_result;
    logic              w_next_zero;
    logic [TAG_W-1:0]  w_next_rd;
    logic              w_next_illegal;

    assign w_accept = in_valid && in_ready;

`ifdef ALU_EXEC_SKID_EN
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_result;
    logic              r_skid_zero;
    logic [TAG_W-1:0]  r_skid_rd;
    logic              r_skid_illegal;
    logic              w_skid_load;
    logic              w_skid_drain;

    // Skid occupied implies the output register is occupied, so ready never sees out_ready.
    assign in_ready     = !r_skid_valid;
    assign w_skid_load  = w_accept && r_out_valid && !out_ready;
    assign w_skid_drain = r_skid_valid && out_ready;
    assign w_out_load   = w_skid_drain || (w_accept && (!r_out_valid || out_ready));

    // Older skid entry has priority over the input for the output register.
    assign w_next_result  = r_skid_valid ? r_skid_result  : w_core_result;
    assign w_next_zero    = r_skid_valid ? r_skid_zero    : w_core_zero;
    assign w_next_rd      = r_skid_valid ? r_skid_rd      : in_rd;
    assign w_next_illegal = r_skid_valid ? r_skid_illegal : w_core_illegal;

    // Skid register: captures an accepted op while the output register is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_valid   <= 1'b0;
            r_skid_result  <= '0;
            r_skid_zero    <= 1'b0;
            r_skid_rd      <= '0;
            r_skid_illegal <= 1'b0;
        end else if (w_skid_load) begin
            r_skid_valid   <= 1'b1;
            r_skid_result  <= w_core_result;
            r_skid_zero    <= w_core_zero;
            r_skid_rd      <= in_rd;
            r_skid_illegal <= w_core_illegal;
        end else if (w_skid_drain) begin
            r_skid_valid   <= 1'b0;
        end
    end
`else
    assign in_ready       = !r_out_valid || out_ready;
    assign w_out_load     = w_accept;
    assign w_next_result  = w_core_result;
    assign w_next_zero    = w_core_zero;
    assign w_next_rd      = in_rd;
    assign w_next_illegal = w_core_illegal;
`endif

    // Output register: load a new entry, or empty once the current one is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_result  <= '0;
            r_out_zero    <= 1'b0;
            r_out_rd      <= '0;
            r_out_illegal <= 1'b0;
        end else if (w_out_load) begin
            r_out_valid   <= 1'b1;
            r_out_result  <= w_next_result;
            r_out_zero    <= w_next_zero;
            r_out_rd      <= w_next_rd;
            r_out_illegal <= w_next_illegal;
        end else if (out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_result  = r_out_result;
    assign out_zero    = r_out_zero;
    assign out_rd      = r_out_rd;
    assign out_illegal = r_out_illegal;

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Registered execute stage directly downstream of the ALU controller. It accepts a 4-bit operation code plus two operands and a destination tag over a valid/ready handshake, computes the ALU result and zero flag, and holds them in an output register for the writeback/branch logic. Backpressure is absorbed by an optional skid buffer so the stage sustains one operation per cycle without a combinational ready path.

## Interface
- DATA_W, 32: operand/result width (≥ 2)
- TAG_W, 5: destination-register tag width
- clk  input  1  clock, rising edge
- rst_n  input  1  reset; asynchronous, active-low
- in_valid  input  1  upstream holds a valid op
- in_ready  output  1  stage can accept this cycle
- in_op  input  4  operation code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
- in_a  input  DATA_W  operand A
- in_b  input  DATA_W  operand B
- in_rd  input  TAG_W  destination tag, passed through unchanged
- out_valid  output  1  output register holds a result
- out_ready  input  1  downstream consumes this cycle
- out_result  output  DATA_W  ALU result
- out_zero  output  1  out_result == 0
- out_rd  output  TAG_W  tag of the result
- out_illegal  output  1  in_op was not one of the six legal codes

## Operation
- Accept when in_valid && in_ready; transfer out when out_valid && out_ready.
- AND/OR/NOR bitwise; ADD/SUB modulo 2^DATA_W, carry/overflow discarded.
- SLT: signed two's-complement compare; result is 1 zero-extended to DATA_W if a < b, else 0.
- Illegal code: out_result = 0, out_zero = 1, out_illegal = 1; still consumes a slot and is delivered in order.
- Ordering strictly FIFO; no op dropped or duplicated under any out_ready pattern.
- Result, zero, tag and illegal travel together as one entry.

## Timing
- Reset, asynchronous: out_valid = 0, out_result = 0, out_zero = 0, out_rd = 0, out_illegal = 0, skid empty; in_ready = 1 from the first cycle after deassertion.
- Latency 1: op accepted at edge N is visible on outputs after edge N (out_valid = 1) when the output register is free or draining.
- Output register loads when empty or when out_ready = 1 in the same cycle; simultaneous accept and drain gives full throughput.
- out_* held stable while out_valid && !out_ready.
- Reset asserted mid-operation discards all held entries immediately; no partial output.

## Configuration
- ALU_EXEC_SKID_EN defined:
  - 1-entry skid register behind the output register.
  - in_ready = !skid_valid, registered; no combinational path from out_ready.
  - On stall (out_valid && !out_ready) the accepted op goes to the skid; the skid moves to output when out_ready.
  - Capacity 2.
- Not defined:
  - No skid; in_ready = !out_valid || out_ready, combinational.
  - Capacity 1; same results and ordering.

## Structure
- Shared package alu_pkg: op-code localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR), op_t 4-bit typedef, legal-op check function; the ALU controller uses the same constants.
- One sub-module: alu_core, combinational (op, a, b → result, zero, illegal), instantiated once ahead of the registers.
- Handshake/skid logic stays in alu_exec_stage.

## Test plan
- Reset, then ops with out_ready = 1: ADD 5+7 → 12, zero = 0; SUB 7−7 → 0, zero = 1; one result per cycle, latency 1.
- SLT signed: a = 0xFFFFFFFF, b = 1 → 1; a = 1, b = 0xFFFFFFFF → 0. ADD 0xFFFFFFFF + 1 → 0, zero = 1 (wrap).
- Logic ops on a = 0xF0F0_00FF, b = 0x0FF0_0F0F: AND 0x00F0_000F, OR 0xFFF0_0FFF, NOR 0x000F_F000.
- Illegal op 0011 with rd = 9 → result 0, zero = 1, illegal = 1, rd = 9, in order between legal ops.
- Random out_ready at 30% with a back-to-back stream of 200 ops: results match the model in order. With ALU_EXEC_SKID_EN, in_ready falls one cycle after a stall and has no combinational dependence on out_ready.
- rst_n pulsed low while out_valid = 1 and the skid is full → all outputs 0 at once; the first op after release gets the correct result.
